tpu_mac_unit: RTL and testbench
===============================

Name: tpu_mac_unit

Overview:
- Single-lane multiply-accumulate element for the TPU datapath.
- On a `sync` strobe it multiplies two unsigned 8-bit operands and truncates the 16-bit product to its 4 most-significant significant bits (a float-like significand, rounded toward zero).
- It adds the truncated product into a 16-bit saturating accumulator.
- The accumulator is copied to `out` only when `out_HL` strobes.

Parameters:
- IN_W, 8, operand width.
- ACC_W, 16, product, accumulator and out width; fixed at 2*IN_W.
- SIG_BITS, 4, significant bits retained from each product.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sync  input  1  start strobe; samples input1/input2.
- out_HL  input  1  output-load strobe; copies the accumulator to out.
- ready  output  1  high when idle and able to accept sync.
- error  output  1  sticky fault flag.
- input1  input  8  operand A, unsigned.
- input2  input  8  operand B, unsigned.
- out  output  16  registered accumulator snapshot.

Behaviour:
- Reset (reset=0, asynchronous) forces the following; it is released synchronously on the next rising edge with reset=1.
  - state=IDLE, acc=0, prod_reg=0, out=0, ready=1, error=0.
- State machine has two states, IDLE and ACC.
- IDLE, sync=1 at edge N:
  - prod_reg <= trunc(input1*input2); the multiply is combinational, full 16-bit.
  - state -> ACC, ready -> 0.
- ACC at edge N+1:
  - acc <= acc + prod_reg, saturating at 0xFFFF.
  - state -> IDLE, ready -> 1.
- Latency: acc holds the new value after edge N+1; the earliest out_HL that captures it is sampled at edge N+2.
- trunc rule:
  - Let p be the index of the product's MSB.
  - If p >= SIG_BITS-1, keep bits [p:p-3] and clear all lower bits.
  - Otherwise keep the value unchanged.
  - A zero product yields 0.
- Overflow: if the unsaturated sum exceeds 0xFFFF, acc=0xFFFF and error<=1.
- sync=1 while in ACC is ignored: no operand capture, accumulation completes normally, error<=1.
- error is sticky; only reset clears it.
- out_HL=1 at an edge: out <= acc, using the acc value before that edge's update. Otherwise out holds.
- out_HL and sync at the same edge are both honoured independently.
- Reset asserted mid-operation aborts the pending accumulation; every register returns to its reset value.
- input1/input2 are only sampled at sync edges; they are don't-care otherwise.

Test Plan:
1. Reset then idle: reset=0 for 10 ns, then 1 -> out=0, ready=1, error=0, no change with sync=0.
2. input1=13, input2=15, sync for one cycle, out_HL two cycles later -> product 195 truncates to 192; out=192 (0x00C0); ready low one cycle then high; error=0.
3. Continue with input1=41, input2=47, sync, out_HL two cycles later -> product 1927 truncates to 1920; out=2112 (0x0840).
4. Small operands: input1=2, input2=3 after reset -> out=6 (no truncation below 4 significant bits); input1=0 -> acc unchanged.
5. Saturation: accumulate 255*255 (truncates to 0xF000) twice -> out=0xFFFF, error=1; further syncs keep 0xFFFF; error cleared only by reset.
6. Protocol: sync held for two consecutive cycles -> second ignored, single accumulation, error=1; reset asserted in the ACC state -> acc=0, out=0, ready=1.

Source files
------------

// File: rtl/tpu_mac_unit_if.sv
// rtl/tpu_mac_unit_if.sv - operand/strobe/result bundle for the MAC lane
interface tpu_mac_unit_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
);
  logic             sync;
  logic             out_HL;
  logic             ready;
  logic             error;
  logic [IN_W-1:0]  input1;
  logic [IN_W-1:0]  input2;
  logic [ACC_W-1:0] out;

  modport master (
    output sync, out_HL, input1, input2,
    input  ready, error, out
  );

  modport slave (
    input  sync, out_HL, input1, input2,
    output ready, error, out
  );
endinterface

// File: rtl/tpu_mac_unit.sv
// rtl/tpu_mac_unit.sv - single-lane multiply, significand-truncate, saturating accumulate
module tpu_mac_unit #(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 2 * IN_W,
  parameter int SIG_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  tpu_mac_unit_if.slave      bus
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_reg;

  logic [IN_W-1:0]  op_a;
  logic [IN_W-1:0]  op_b;
  logic [ACC_W-1:0] product;
  logic [ACC_W-1:0] smear;
  logic [ACC_W-1:0] trunc_prod;
  logic [ACC_W:0]   sum;

  assign op_a    = bus.input1;
  assign op_b    = bus.input2;
  assign product = ACC_W'(op_a) * ACC_W'(op_b);

  // Smearing the MSB rightwards marks bits p..0; removing those below p-3
  // leaves a mask of the top SIG_BITS significant bits (or all, if fewer).
  always_comb begin
    smear = product;
    for (int i = 1; i < ACC_W; i = i * 2) begin
      smear = smear | (smear >> i);
    end
    trunc_prod = product & (smear & ~(smear >> SIG_BITS));
  end

  assign sum = {1'b0, acc} + {1'b0, prod_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      prod_reg  <= '0;
      bus.out   <= '0;
      bus.ready <= 1'b1;
      bus.error <= 1'b0;
    end else begin
      if (bus.out_HL) begin
        bus.out <= acc;
      end
      case (state)
        IDLE: begin
          if (bus.sync) begin
            prod_reg  <= trunc_prod;
            state     <= ACC;
            bus.ready <= 1'b0;
          end
        end
        ACC: begin
          if (sum[ACC_W]) begin
            acc       <= '1;
            bus.error <= 1'b1;
          end else begin
            acc <= sum[ACC_W-1:0];
          end
          // A strobe while busy is dropped but flagged.
          if (bus.sync) begin
            bus.error <= 1'b1;
          end
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_mac_unit.sv
// tb/tb_tpu_mac_unit.sv - directed and randomized checks of tpu_mac_unit against an arithmetic model
module tb_tpu_mac_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tpu_mac_unit_if bus ();

  tpu_mac_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int m_acc       = 0;
  int m_err       = 0;

  function automatic int trunc_ref(input int prod);
    int p;
    p = -1;
    for (int i = 0; i < 16; i++) begin
      if ((prod >> i) & 1) p = i;
    end
    if (p < 3) return prod;
    return (prod / (1 << (p - 3))) * (1 << (p - 3));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accumulate(input int a, input int b);
    int s;
    s = m_acc + trunc_ref(a * b);
    if (s > 65535) begin
      m_acc = 65535;
      m_err = 1;
    end else begin
      m_acc = s;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    bus.sync   = 1'b0;
    bus.out_HL = 1'b0;
    #2;
    chk("rst_out", int'(bus.out), 0);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_error", int'(bus.error), 0);
    @(negedge clk);
    reset = 1'b1;
    m_acc = 0;
    m_err = 0;
  endtask

  // One sync, then the load strobe two edges later; optionally also load on the sync edge.
  task automatic op(input string tag, input int a, input int b, input bit hl_at_sync);
    int pre;
    pre        = m_acc;
    bus.input1 = 8'(a);
    bus.input2 = 8'(b);
    bus.sync   = 1'b1;
    bus.out_HL = hl_at_sync;
    tick();
    bus.sync   = 1'b0;
    bus.out_HL = 1'b0;
    bus.input1 = 8'($urandom);
    bus.input2 = 8'($urandom);
    chk({tag, "_busy"}, int'(bus.ready), 0);
    if (hl_at_sync) chk({tag, "_hl_old"}, int'(bus.out), pre);
    tick();
    model_accumulate(a, b);
    chk({tag, "_ready"}, int'(bus.ready), 1);
    bus.out_HL = 1'b1;
    tick();
    bus.out_HL = 1'b0;
    chk({tag, "_out"}, int'(bus.out), m_acc);
    chk({tag, "_err"}, int'(bus.error), m_err);
  endtask

  initial begin
    int a;
    int b;
    reset      = 1'b0;
    bus.sync   = 1'b0;
    bus.out_HL = 1'b0;
    bus.input1 = '0;
    bus.input2 = '0;

    // reset, then idle with no strobes
    do_reset();
    repeat (3) tick();
    chk("idle_out", int'(bus.out), 0);
    chk("idle_ready", int'(bus.ready), 1);
    chk("idle_error", int'(bus.error), 0);

    // truncation examples from the datasheet
    op("t195", 13, 15, 1'b0);
    chk("t195_abs", int'(bus.out), 192);
    op("t1927", 41, 47, 1'b0);
    chk("t1927_abs", int'(bus.out), 2112);

    // small operands and zero
    do_reset();
    op("small", 2, 3, 1'b0);
    chk("small_abs", int'(bus.out), 6);
    op("zero", 0, 200, 1'b0);
    chk("zero_abs", int'(bus.out), 6);
    op("overlap", 7, 1, 1'b1);

    // saturation and sticky error
    do_reset();
    op("sat1", 255, 255, 1'b0);
    chk("sat1_abs", int'(bus.out), 16'hF000);
    op("sat2", 255, 255, 1'b0);
    chk("sat2_abs", int'(bus.out), 16'hFFFF);
    chk("sat2_errabs", int'(bus.error), 1);
    op("sat3", 3, 3, 1'b0);
    chk("sat3_abs", int'(bus.out), 16'hFFFF);

    // sync held for two edges: second strobe dropped, error raised
    do_reset();
    bus.input1 = 8'd10;
    bus.input2 = 8'd10;
    bus.sync   = 1'b1;
    tick();
    bus.input1 = 8'd200;
    bus.input2 = 8'd200;
    tick();
    bus.sync = 1'b0;
    model_accumulate(10, 10);
    m_err = 1;
    tick();
    bus.out_HL = 1'b1;
    tick();
    bus.out_HL = 1'b0;
    chk("dbl_out", int'(bus.out), m_acc);
    chk("dbl_abs", int'(bus.out), 96);
    chk("dbl_err", int'(bus.error), 1);

    // reset arriving while the accumulation is pending
    op("pre_abort", 9, 9, 1'b0);
    bus.input1 = 8'd100;
    bus.input2 = 8'd100;
    bus.sync   = 1'b1;
    tick();
    bus.sync = 1'b0;
    reset    = 1'b0;
    #1;
    chk("abort_out", int'(bus.out), 0);
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_err", int'(bus.error), 0);
    @(negedge clk);
    reset = 1'b1;
    m_acc = 0;
    m_err = 0;
    tick();
    bus.out_HL = 1'b1;
    tick();
    bus.out_HL = 1'b0;
    chk("abort_acc", int'(bus.out), 0);

    // randomized operand stream
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) begin
        a = int'($urandom_range(0, 7));
        b = int'($urandom_range(0, 7));
      end else begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
      end
      op($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
